// File: rtl/mpu_i2c_target.sv
// I2C responder emulating the MPU accelerometer register file.
// Define MPU_TARGET_WRITE_EN to accept data-byte writes (PWR_MGMT_1, wr_*).
module mpu_i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h68,
    parameter logic [7:0] WHO_AM_I    = 8'h68
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic        sample_valid,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    output logic        busy,
    output logic        wr_strobe,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK,
        WDATA, WDATA_ACK, RDATA, MACK
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  scl_sync_q, scl_sync_d;
    logic [2:0]  sda_sync_q, sda_sync_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  sr_q, sr_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [7:0]  pwr_q, pwr_d;
    logic        ack_q, ack_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic [47:0] live_q, live_d;
    logic [47:0] shadow_q, shadow_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;

    logic        scl_s, scl_p, sda_s, sda_p;
    logic        scl_rise, scl_fall, start_c, stop_c;
    logic [7:0]  rd_byte;

    function automatic logic [7:0] reg_read(input logic [7:0]  idx,
                                            input logic [47:0] d,
                                            input logic [7:0]  pwr);
        case (idx)
            8'h3B:   reg_read = d[47:40];
            8'h3C:   reg_read = d[39:32];
            8'h3D:   reg_read = d[31:24];
            8'h3E:   reg_read = d[23:16];
            8'h3F:   reg_read = d[15:8];
            8'h40:   reg_read = d[7:0];
            8'h6B:   reg_read = pwr;
            8'h75:   reg_read = WHO_AM_I;
            default: reg_read = 8'h00;
        endcase
    endfunction

    assign scl_s    = scl_sync_q[1];
    assign scl_p    = scl_sync_q[2];
    assign sda_s    = sda_sync_q[1];
    assign sda_p    = sda_sync_q[2];
    assign scl_rise = scl_s & ~scl_p;
    assign scl_fall = ~scl_s & scl_p;
    assign start_c  = scl_s & scl_p & sda_p & ~sda_s;
    assign stop_c   = scl_s & scl_p & ~sda_p & sda_s;

    // First read byte is fetched in the same cycle the shadow is captured.
    assign rd_byte = reg_read(ptr_q, (state_q == ADDR_ACK) ? live_q : shadow_q, pwr_q);

    always_comb begin
        state_d     = state_q;
        scl_sync_d  = {scl_sync_q[1:0], scl_in};
        sda_sync_d  = {sda_sync_q[1:0], sda_in};
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        pwr_d       = pwr_q;
        ack_d       = ack_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        shadow_d    = shadow_q;
        live_d      = sample_valid ? {sample_x, sample_y, sample_z} : live_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        if (start_c) begin
            state_d  = ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
        end else if (stop_c) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR, REG, WDATA: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        sr_d  = {sr_q[6:0], sda_s};
                        cnt_d = cnt_q + 4'd1;
                    end
                    if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d = 4'd0;
                        if (state_q == ADDR) begin
                            if (sr_q[7:1] == TARGET_ADDR) begin
                                state_d  = ADDR_ACK;
                                sda_oe_d = 1'b1;
                                busy_d   = 1'b1;
                            end else begin
                                state_d = IDLE;
                                busy_d  = 1'b0;
                            end
                        end else if (state_q == REG) begin
                            state_d  = REG_ACK;
                            sda_oe_d = 1'b1;
                        end else begin
`ifdef MPU_TARGET_WRITE_EN
                            state_d  = WDATA_ACK;
                            sda_oe_d = 1'b1;
`else
                            state_d  = IDLE;
`endif
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = 4'd0;
                        if (sr_q[0]) begin
                            shadow_d = live_q;
                            tx_d     = rd_byte;
                            sda_oe_d = ~rd_byte[7];
                            state_d  = RDATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = REG;
                        end
                    end
                end
                REG_ACK: begin
                    if (scl_fall) begin
                        ptr_d    = sr_q;
                        cnt_d    = 4'd0;
                        sda_oe_d = 1'b0;
                        state_d  = WDATA;
                    end
                end
`ifdef MPU_TARGET_WRITE_EN
                WDATA_ACK: begin
                    if (scl_fall) begin
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = ptr_q;
                        wr_data_d   = sr_q;
                        if (ptr_q == 8'h6B) pwr_d = sr_q;
                        ptr_d    = ptr_q + 8'd1;
                        cnt_d    = 4'd0;
                        sda_oe_d = 1'b0;
                        state_d  = WDATA;
                    end
                end
`endif
                RDATA: begin
                    if (scl_rise) cnt_d = cnt_q + 4'd1;
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            ptr_d    = ptr_q + 8'd1;
                            cnt_d    = 4'd0;
                            sda_oe_d = 1'b0;
                            state_d  = MACK;
                        end else begin
                            tx_d     = {tx_q[6:0], 1'b0};
                            sda_oe_d = ~tx_q[6];
                        end
                    end
                end
                MACK: begin
                    if (scl_rise) ack_d = sda_s;
                    if (scl_fall) begin
                        if (!ack_q) begin
                            tx_d     = rd_byte;
                            sda_oe_d = ~rd_byte[7];
                            cnt_d    = 4'd0;
                            state_d  = RDATA;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            scl_sync_q  <= 3'b000;
            sda_sync_q  <= 3'b000;
            cnt_q       <= 4'd0;
            sr_q        <= 8'h00;
            tx_q        <= 8'h00;
            ptr_q       <= 8'h00;
            pwr_q       <= 8'h40;
            ack_q       <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            live_q      <= 48'h0;
            shadow_q    <= 48'h0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 8'h00;
            wr_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            pwr_q       <= pwr_d;
            ack_q       <= ack_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            live_q      <= live_d;
            shadow_q    <= shadow_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule
